// File: rtl/mem_port_arbiter.sv
// Shares the single memory port of the multicycle CPU between instruction
// fetch, data access and the external loader. It runs one fixed-latency
// access at a time and returns read data together with a one-cycle ack.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   if_req/if_addr/if_ack             fetch requester (read only)
//   dm_req/dm_we/dm_addr/dm_wdata/dm_ack   data requester (lw/sw)
//   ld_req/ld_we/ld_addr/ld_wdata/ld_ack   loader/debug requester
//   rdata, mis_err                    shared response data, misalignment flag
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory side
//   busy, grant                       status: access in flight, its owner
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] rdata,
    output logic          mis_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    grant
);

    localparam int unsigned CW = 4;
    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_IF   = 2'd1;
    localparam logic [1:0] G_DM   = 2'd2;
    localparam logic [1:0] G_LD   = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [AW-1:0] lat_addr, lat_addr_d;
    logic [DW-1:0] lat_wdata, lat_wdata_d;
    logic          lat_we, lat_we_d;
    logic          last_ld, last_ld_d;
    logic          lat_mis;

    logic          if_ack_d, dm_ack_d, ld_ack_d, mis_err_d;
    logic          mem_en_d, mem_we_d, busy_d;
    logic [DW-1:0] rdata_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;
    logic [1:0]    grant_d;

    // Arbitration result for the current IDLE cycle
    logic          cpu_req, pick_ld;
    logic [1:0]    win;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_we, win_mis;

    assign lat_mis = (lat_addr[1:0] != 2'b00);

    // Round-robin between CPU group and loader on last_ld; dm beats if inside CPU group
    always_comb begin
        cpu_req   = if_req | dm_req;
        pick_ld   = ld_req & (~cpu_req | ~last_ld);
        win       = G_NONE;
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        if (pick_ld) begin
            win       = G_LD;
            win_addr  = ld_addr;
            win_wdata = ld_wdata;
            win_we    = ld_we;
        end else if (dm_req) begin
            win       = G_DM;
            win_addr  = dm_addr;
            win_wdata = dm_wdata;
            win_we    = dm_we;
        end else if (if_req) begin
            win       = G_IF;
            win_addr  = if_addr;
        end
        win_mis = (win_addr[1:0] != 2'b00);
    end

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_addr_d  = lat_addr;
        lat_wdata_d = lat_wdata;
        lat_we_d    = lat_we;
        last_ld_d   = last_ld;
        grant_d     = grant;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        ld_ack_d    = 1'b0;
        mis_err_d   = 1'b0;
        rdata_d     = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        busy_d      = 1'b0;

        unique case (state)
            IDLE: begin
                if (win != G_NONE) begin
                    state_d     = ACCESS;
                    cnt_d       = CW'(MEM_LAT - 1);
                    lat_addr_d  = win_addr;
                    lat_wdata_d = win_wdata;
                    lat_we_d    = win_we;
                    grant_d     = win;
                    busy_d      = 1'b1;
                    // First ACCESS cycle: the only one carrying the write strobe
                    mem_en_d    = ~win_mis;
                    mem_we_d    = win_we & ~win_mis;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
                if (cnt == '0) begin
                    state_d   = RESP;
                    if_ack_d  = (grant == G_IF);
                    dm_ack_d  = (grant == G_DM);
                    ld_ack_d  = (grant == G_LD);
                    mis_err_d = lat_mis;
                    rdata_d   = (lat_we | lat_mis) ? '0 : mem_rdata;
                    last_ld_d = (grant == G_LD);
                end else begin
                    cnt_d       = cnt - CW'(1);
                    mem_en_d    = ~lat_mis;
                    mem_addr_d  = lat_addr;
                    mem_wdata_d = lat_wdata;
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = G_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            last_ld   <= 1'b1;
            grant     <= G_NONE;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            ld_ack    <= 1'b0;
            mis_err   <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat_addr  <= lat_addr_d;
            lat_wdata <= lat_wdata_d;
            lat_we    <= lat_we_d;
            last_ld   <= last_ld_d;
            grant     <= grant_d;
            if_ack    <= if_ack_d;
            dm_ack    <= dm_ack_d;
            ld_ack    <= ld_ack_d;
            mis_err   <= mis_err_d;
            rdata     <= rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single unified memory port of the multicycle CPU and shares it between three requesters: instruction fetch (IF state), data access (MEM state, lw/sw) and an external program loader/debug port.
- Sits between the CPU FSM/datapath and the memory.
- Runs one access at a time, with a fixed latency of MEM_LAT cycles, and returns read data with a one-cycle ack.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 2, memory read latency in cycles; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- if_req  in  1  fetch request (read only).
- if_addr  in  AW  fetch address.
- if_ack  out  1  fetch done, one-cycle pulse.
- dm_req  in  1  data request.
- dm_we  in  1  data write enable (1 = sw).
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_ack  out  1  data done, one-cycle pulse.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write enable.
- ld_addr  in  AW  loader address.
- ld_wdata  in  DW  loader write data.
- ld_ack  out  1  loader done, one-cycle pulse.
- rdata  out  DW  read data, valid while any ack is high; shared by all requesters.
- mis_err  out  1  pulses with ack when the granted address was misaligned.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after a mem_en rising edge.
- busy  out  1  high in ACCESS and RESP.
- grant  out  2  owner of the in-flight access: 0 = none, 1 = fetch, 2 = data, 3 = loader.

Behaviour:
- Reset:
  - rst_n low at a posedge forces state IDLE.
  - All outputs go to 0; last_ld is set to 1; the latched request registers clear.
  - Reset mid-access abandons the access: no ack is issued and no further memory strobes occur.
- States:
  - IDLE -> ACCESS when any request is pending.
  - ACCESS -> RESP when the latency counter expires.
  - RESP -> IDLE unconditionally.
- IDLE:
  - Requests are sampled only in IDLE.
  - Arbitration between the CPU group (dm, if) and the loader is round-robin on last_ld:
    - If both groups request, the group not served last wins.
    - If only one group requests, that group wins.
  - Inside the CPU group, dm beats if.
  - The winner's addr, we and wdata are latched; grant is set; counter = MEM_LAT - 1.
- ACCESS (exactly MEM_LAT cycles):
  - mem_en = 1 and mem_addr / mem_wdata hold the latched values for all ACCESS cycles.
  - mem_we = latched_we only in the first ACCESS cycle.
  - The counter decrements each cycle; at 0 the next edge moves to RESP and captures mem_rdata into the rdata register.
  - Writes still wait the full latency.
- Misaligned access (latched addr[1:0] != 0):
  - No memory access is made: mem_en and mem_we stay 0 during ACCESS.
  - The timing is unchanged.
  - In RESP, rdata = 0 and mis_err = 1.
- RESP (one cycle):
  - The granted requester's ack = 1 and rdata is valid.
  - For a write, rdata = 0.
  - last_ld is updated: 1 if the loader was served, else 0.
  - grant and busy stay high this cycle; both are 0 in the following IDLE cycle.
- Timing:
  - A request first seen in IDLE at cycle t gets ack at cycle t + MEM_LAT + 1.
  - Minimum spacing between accesses is MEM_LAT + 2 cycles.
- Handshake:
  - A requester holds req and its operands stable until it sees ack.
  - It must deassert req in the cycle after ack, or it issues a new request.
  - Request changes during ACCESS/RESP are ignored; the latched values are used.
- Requests that are not granted are not lost: they are re-evaluated at the next IDLE cycle.
- Simultaneous if_req and dm_req is legal (not produced by the FSM) and resolves dm first.
- Width rules:
  - The counter is 4 bits.
  - Address and data are passed unmodified; there is no byte-lane logic.

Test Plan:
- Reset then idle, MEM_LAT=2:
  - Stimulus: hold rst_n=0 for 3 cycles, no requests.
  - Required: all outputs 0 and grant=0 throughout; grant stays 0 after release.
- Fetch read:
  - Stimulus: if_req with if_addr=0x00000010, memory returns 0x8C010004.
  - Required: mem_en high for 2 cycles with mem_addr=0x10 and mem_we=0; if_ack at t+3 with rdata=0x8C010004; grant=1 during the access.
- Data store then load:
  - Stimulus: dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF, followed by a load of 0x20.
  - Required: mem_we high for exactly 1 cycle; dm_ack with rdata=0; the second dm_ack returns 0xDEADBEEF.
- Round-robin:
  - Stimulus: ld_req and dm_req held continuously after reset.
  - Required: grant sequence 2, 3, 2, 3; each ack is followed by IDLE for 1 cycle.
- Misaligned:
  - Stimulus: dm_addr=0x22.
  - Required: mem_en stays 0; dm_ack and mis_err both pulse at t+3 with rdata=0.
- Reset mid-access:
  - Stimulus: rst_n=0 in the 2nd ACCESS cycle of a loader read.
  - Required: no ld_ack; mem_en=0 next cycle; after release an if_req is served normally.
